// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter for the shared write port of the write FIFO
// Winner holds the port for up to MAX_BURST beats; writes are throttled so the FIFO cannot overflow.
module fifo_wr_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int DATA_W    = 8,
   parameter int DEPTH     = 8,
   parameter int CNT_W     = 4,
   parameter int MAX_BURST = 4,
   localparam int GID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                      i_clock,
   input  logic                      i_rst,
   input  logic [NUM_REQ-1:0]        i_req_valid,
   input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
   output logic [NUM_REQ-1:0]        o_req_ready,
   input  logic                      i_fifo_full,
   input  logic [CNT_W-1:0]          i_fifo_cnt,
   output logic                      o_fifo_wr,
   output logic [DATA_W-1:0]         o_fifo_din,
   output logic [GID_W-1:0]          o_grant_id,
   output logic                      o_busy,
   output logic                      o_ovf_err
);

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_BURST = 1'b1;

   localparam logic [CNT_W:0] LP_DEPTH     = (CNT_W+1)'(DEPTH);
   localparam logic [3:0]     LP_MAX_BURST = 4'(MAX_BURST);

   logic [0:0]        r_state;
   logic [GID_W-1:0]  r_ptr;
   logic [3:0]        r_beat_cnt;
   logic [GID_W-1:0]  r_grant_id;
   logic              r_fifo_wr;
   logic [DATA_W-1:0] r_fifo_din;
   logic              r_ovf_err;

   logic [CNT_W:0]    w_sum;
   logic              w_can_wr;
   logic              w_any_valid;
   logic [GID_W-1:0]  w_idx;
   logic [GID_W-1:0]  w_grant;
   logic              w_gnt_valid;
   logic [DATA_W-1:0] w_gnt_data;
   logic              w_accept;
   logic [3:0]        w_beat_nxt;
   logic [GID_W-1:0]  w_ptr_nxt;

   // The registered write has not reached fifo_cnt yet, so it is counted here.
   assign w_sum       = {1'b0, i_fifo_cnt} + {{CNT_W{1'b0}}, r_fifo_wr};
   assign w_can_wr    = !i_fifo_full && (w_sum < LP_DEPTH);
   assign w_any_valid = |i_req_valid;

   always_comb begin
      w_grant = r_ptr;
      w_idx   = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         w_idx = GID_W'((int'(r_ptr) + k) % NUM_REQ);
         if (i_req_valid[w_idx]) begin
            w_grant = w_idx;
         end
      end
   end

   always_comb begin
      w_gnt_valid = 1'b0;
      w_gnt_data  = '0;
      o_req_ready = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (r_grant_id == GID_W'(i)) begin
            w_gnt_valid    = i_req_valid[i];
            w_gnt_data     = i_req_data[i*DATA_W +: DATA_W];
            o_req_ready[i] = (r_state == S_BURST) && w_can_wr;
         end
      end
   end

   assign w_accept   = (r_state == S_BURST) && w_gnt_valid && w_can_wr;
   assign w_beat_nxt = r_beat_cnt + 4'd1;
   assign w_ptr_nxt  = (r_grant_id == GID_W'(NUM_REQ - 1)) ? '0 : r_grant_id + GID_W'(1);

   always_ff @(posedge i_clock or posedge i_rst) begin
      if (i_rst) begin
         r_state    <= S_IDLE;
         r_ptr      <= '0;
         r_beat_cnt <= '0;
         r_grant_id <= '0;
         r_fifo_wr  <= 1'b0;
         r_fifo_din <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_fifo_wr <= 1'b0;
               if (w_any_valid) begin
                  r_grant_id <= w_grant;
                  r_beat_cnt <= '0;
                  r_state    <= S_BURST;
               end
            end
            S_BURST: begin
               if (w_accept) begin
                  r_fifo_wr  <= 1'b1;
                  r_fifo_din <= w_gnt_data;
                  r_beat_cnt <= w_beat_nxt;
                  if (w_beat_nxt == LP_MAX_BURST) begin
                     r_ptr   <= w_ptr_nxt;
                     r_state <= S_IDLE;
                  end
               end else begin
                  r_fifo_wr <= 1'b0;
                  // A full FIFO with valid still high stalls here indefinitely.
                  if (!w_gnt_valid) begin
                     r_ptr   <= w_ptr_nxt;
                     r_state <= S_IDLE;
                  end
               end
            end
            default: begin
               r_fifo_wr <= 1'b0;
               r_state   <= S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge i_clock or posedge i_rst) begin
      if (i_rst) begin
         r_ovf_err <= 1'b0;
      end else if (r_fifo_wr && i_fifo_full) begin
         r_ovf_err <= 1'b1;
      end
   end

   assign o_fifo_wr  = r_fifo_wr;
   assign o_fifo_din = r_fifo_din;
   assign o_grant_id = r_grant_id;
   assign o_busy     = (r_state == S_BURST);
   assign o_ovf_err  = r_ovf_err;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

   logic        clk;
   logic        rst;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_ready;
   logic        fifo_full;
   logic [3:0]  fifo_cnt;
   logic        fifo_wr;
   logic [7:0]  fifo_din;
   logic [1:0]  grant_id;
   logic        busy;
   logic        ovf_err;

   int n_checks;
   int n_errors;
   int nxt [4];
   int wr_idx;
   int iters;
   int acc_id;
   logic [3:0] acc;
   logic [7:0] t1_data [4];
   logic [7:0] exp_seq [24];

   fifo_wr_arbiter #(
      .NUM_REQ(4), .DATA_W(8), .DEPTH(8), .CNT_W(4), .MAX_BURST(4)
   ) u_dut (
      .i_clock     (clk),
      .i_rst       (rst),
      .i_req_valid (req_valid),
      .i_req_data  (req_data),
      .o_req_ready (req_ready),
      .i_fifo_full (fifo_full),
      .i_fifo_cnt  (fifo_cnt),
      .o_fifo_wr   (fifo_wr),
      .o_fifo_din  (fifo_din),
      .o_grant_id  (grant_id),
      .o_busy      (busy),
      .o_ovf_err   (ovf_err)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      req_valid = '0;
      req_data  = '0;
      fifo_full = 1'b0;
      fifo_cnt  = '0;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      clk       = 1'b0;
      rst       = 1'b1;
      req_valid = '0;
      req_data  = '0;
      fifo_full = 1'b0;
      fifo_cnt  = '0;
      t1_data[0] = 8'h11; t1_data[1] = 8'h22; t1_data[2] = 8'h33; t1_data[3] = 8'h44;
      for (int r = 0; r < 4; r++)
         for (int k = 0; k < 4; k++) exp_seq[r*4+k] = {4'(r), 4'(k)};
      for (int r = 0; r < 4; r++)
         for (int k = 0; k < 2; k++) exp_seq[16+r*2+k] = {4'(r), 4'(k+4)};

      #2;
      check_eq("rst_fifo_wr", 32'(fifo_wr), 0);
      check_eq("rst_fifo_din", 32'(fifo_din), 0);
      check_eq("rst_busy", 32'(busy), 0);
      check_eq("rst_grant", 32'(grant_id), 0);
      check_eq("rst_ovf", 32'(ovf_err), 0);
      check_eq("rst_ready", 32'(req_ready), 0);
      tick();
      rst = 1'b0;

      // Test 1: single requester, one full burst
      req_data[7:0] = t1_data[0];
      req_valid     = 4'b0001;
      #1;
      check_eq("t1_idle_ready", 32'(req_ready), 0);
      tick();
      check_eq("t1_busy", 32'(busy), 1);
      check_eq("t1_grant", 32'(grant_id), 0);
      check_eq("t1_bubble_wr", 32'(fifo_wr), 0);
      for (int b = 0; b < 4; b++) begin
         #1;
         check_eq("t1_ready", 32'(req_ready), 32'h1);
         tick();
         check_eq("t1_wr", 32'(fifo_wr), 1);
         check_eq("t1_din", 32'(fifo_din), 32'(t1_data[b]));
         if (b < 3) req_data[7:0] = t1_data[b+1];
         else req_valid = 4'b0000;
      end
      check_eq("t1_exit_busy", 32'(busy), 0);
      req_valid = 4'b0011;
      tick();
      check_eq("t1_ptr_grant", 32'(grant_id), 1);
      check_eq("t1_post_wr", 32'(fifo_wr), 0);
      req_valid = 4'b0000;
      tick();
      tick();

      // Test 2: four requesters, six beats each, drained FIFO
      do_reset();
      for (int i = 0; i < 4; i++) nxt[i] = 0;
      wr_idx = 0;
      iters  = 0;
      while (wr_idx < 24 && iters < 200) begin
         for (int i = 0; i < 4; i++) begin
            req_valid[i]        = (nxt[i] < 6);
            req_data[i*8 +: 8]  = {4'(i), 4'(nxt[i])};
         end
         #1;
         check_eq("t2_onehot", 32'($onehot0(req_ready)), 1);
         acc    = req_ready & req_valid;
         acc_id = 0;
         for (int i = 0; i < 4; i++) if (acc[i]) acc_id = i;
         tick();
         iters++;
         if (acc != 4'b0000) begin
            nxt[acc_id]++;
            check_eq("t2_wr", 32'(fifo_wr), 1);
            check_eq("t2_din", 32'(fifo_din), 32'(exp_seq[wr_idx]));
            check_eq("t2_grant", 32'(grant_id), 32'(exp_seq[wr_idx][7:4]));
            wr_idx++;
         end else begin
            check_eq("t2_nowr", 32'(fifo_wr), 0);
         end
      end
      check_eq("t2_writes", 32'(wr_idx), 24);
      check_eq("t2_cycles", 32'(iters), 35);
      req_valid = 4'b0000;
      tick();
      tick();
      check_eq("t2_idle_busy", 32'(busy), 0);

      // Test 3: one free FIFO slot
      do_reset();
      fifo_cnt        = 4'd7;
      req_valid       = 4'b0100;
      req_data[23:16] = 8'hA5;
      tick();
      check_eq("t3_busy", 32'(busy), 1);
      check_eq("t3_grant", 32'(grant_id), 2);
      #1;
      check_eq("t3_ready", 32'(req_ready), 32'h4);
      tick();
      check_eq("t3_wr", 32'(fifo_wr), 1);
      check_eq("t3_din", 32'(fifo_din), 32'hA5);
      check_eq("t3_pending_ready", 32'(req_ready), 0);
      tick();
      fifo_cnt  = 4'd8;
      fifo_full = 1'b1;
      #1;
      check_eq("t3_stall_wr", 32'(fifo_wr), 0);
      check_eq("t3_full_ready", 32'(req_ready), 0);
      for (int c = 0; c < 3; c++) begin
         tick();
         check_eq("t3_hold_wr", 32'(fifo_wr), 0);
         check_eq("t3_hold_ready", 32'(req_ready), 0);
         check_eq("t3_hold_grant", 32'(grant_id), 2);
         check_eq("t3_hold_busy", 32'(busy), 1);
      end
      check_eq("t3_ovf", 32'(ovf_err), 0);
      fifo_cnt        = 4'd7;
      fifo_full       = 1'b0;
      req_data[23:16] = 8'h5A;
      #1;
      check_eq("t3_resume_ready", 32'(req_ready), 32'h4);
      tick();
      check_eq("t3_resume_wr", 32'(fifo_wr), 1);
      check_eq("t3_resume_din", 32'(fifo_din), 32'h5A);
      req_valid = 4'b0000;
      tick();
      tick();

      // Test 4: requester 1 drops valid after two beats
      do_reset();
      req_valid       = 4'b0010;
      req_data[15:8]  = 8'h51;
      tick();
      check_eq("t4_grant1", 32'(grant_id), 1);
      tick();
      check_eq("t4_din0", 32'(fifo_din), 32'h51);
      req_data[15:8] = 8'h52;
      tick();
      check_eq("t4_din1", 32'(fifo_din), 32'h52);
      req_valid       = 4'b1001;
      req_data[7:0]   = 8'h0C;
      req_data[31:24] = 8'h3C;
      tick();
      check_eq("t4_exit_busy", 32'(busy), 0);
      check_eq("t4_exit_wr", 32'(fifo_wr), 0);
      tick();
      check_eq("t4_wrap_grant", 32'(grant_id), 3);
      check_eq("t4_wrap_busy", 32'(busy), 1);
      tick();
      check_eq("t4_wrap_din", 32'(fifo_din), 32'h3C);
      req_valid = 4'b0000;
      tick();
      tick();

      // Test 5: reset one cycle after an accepted beat
      do_reset();
      req_valid       = 4'b0100;
      req_data[23:16] = 8'h77;
      tick();
      tick();
      check_eq("t5_pre_wr", 32'(fifo_wr), 1);
      check_eq("t5_pre_din", 32'(fifo_din), 32'h77);
      check_eq("t5_pre_grant", 32'(grant_id), 2);
      rst = 1'b1;
      #1;
      check_eq("t5_rst_wr", 32'(fifo_wr), 0);
      check_eq("t5_rst_din", 32'(fifo_din), 0);
      check_eq("t5_rst_busy", 32'(busy), 0);
      check_eq("t5_rst_grant", 32'(grant_id), 0);
      check_eq("t5_rst_ready", 32'(req_ready), 0);
      req_valid = 4'b0000;
      tick();
      rst = 1'b0;

      // Test 6: FIFO full blocks writes; sticky overflow flag
      do_reset();
      fifo_full     = 1'b1;
      fifo_cnt      = 4'd3;
      req_valid     = 4'b0001;
      req_data[7:0] = 8'h99;
      tick();
      check_eq("t6_busy", 32'(busy), 1);
      for (int c = 0; c < 4; c++) begin
         check_eq("t6_ready", 32'(req_ready), 0);
         tick();
         check_eq("t6_wr", 32'(fifo_wr), 0);
      end
      check_eq("t6_ovf", 32'(ovf_err), 0);
      fifo_full = 1'b0;
      fifo_cnt  = 4'd0;
      #1;
      check_eq("t6_ready_free", 32'(req_ready), 32'h1);
      tick();
      check_eq("t6_wr_free", 32'(fifo_wr), 1);
      fifo_full = 1'b1;
      tick();
      check_eq("t6_ovf_set", 32'(ovf_err), 1);
      fifo_full = 1'b0;
      req_valid = 4'b0000;
      tick();
      check_eq("t6_ovf_sticky", 32'(ovf_err), 1);
      do_reset();
      check_eq("t6_ovf_clr", 32'(ovf_err), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
